// File: rtl/rvsteel_gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rvsteel_gpio_pkg
//  Purpose  : Shared definitions for the GPIO input conditioner: the arming
//             state encoding and the default debounce window.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rvsteel_gpio_pkg;

    // 10 ms stability window at a 50 MHz clock.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Global arming state. SETTLE lets the debounced values converge after
    // reset without reporting the start-up transitions as events.
    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        ARMED  = 1'b1
    } arm_state_e;

endpackage : rvsteel_gpio_pkg
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_debounce
//  Purpose  : One GPIO line: 2-flop synchronizer, stability counter and
//             debounced output register.
//  Ports    : clk_i         - clock, rising edge
//             rst_ni        - asynchronous active-low reset
//             pad_i         - raw pad value (asynchronous to clk_i)
//             stable_o      - debounced line value (registered)
//             stable_next_o - value stable_o takes on the next edge, so the
//                             parent can flag edges on the same clock edge
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_debounce
    import rvsteel_gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    output logic stable_o,
    output logic stable_next_o
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before it clears, so
    // clog2(DEBOUNCE_CYCLES) bits hold every value it can take.
    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synchronized value agrees with the stable value
    // restarts the window; the counter clears on acceptance, so it never wraps.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pad_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o      = stable_q;
    assign stable_next_o = stable_d;

endmodule : gpio_debounce
`default_nettype wire

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_input_conditioner
//  Purpose  : Debounces GPIO_WIDTH asynchronous input lines and raises sticky
//             per-line edge events once the debounced values have settled.
//  Ports    : clock        - clock, rising edge
//             reset        - asynchronous active-low reset
//             gpio_input   - raw pad values
//             gpio_oe      - 1 = line is an output, its events are ignored
//             rise_enable  - per-line rising-edge event enable
//             fall_enable  - per-line falling-edge event enable
//             irq_clear    - write-one-to-clear of pending flags
//             gpio_stable  - debounced line values
//             irq_pending  - sticky per-line event flags
//             irq          - OR of all pending flags
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_input_conditioner
    import rvsteel_gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] gpio_input,
    input  logic [GPIO_WIDTH-1:0] gpio_oe,
    input  logic [GPIO_WIDTH-1:0] rise_enable,
    input  logic [GPIO_WIDTH-1:0] fall_enable,
    input  logic [GPIO_WIDTH-1:0] irq_clear,
    output logic [GPIO_WIDTH-1:0] gpio_stable,
    output logic [GPIO_WIDTH-1:0] irq_pending,
    output logic                  irq
);

    // Arming waits one full pad-to-stable latency so that lines sitting high
    // at reset release reach their value before events are reported.
    localparam int unsigned      ARM_W    = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 1);

    logic [GPIO_WIDTH-1:0] stable_next;
    logic [GPIO_WIDTH-1:0] rise_evt;
    logic [GPIO_WIDTH-1:0] fall_evt;
    logic [GPIO_WIDTH-1:0] pending_set;
    logic [GPIO_WIDTH-1:0] pending_q;
    logic [GPIO_WIDTH-1:0] pending_d;

    arm_state_e            state_q;
    arm_state_e            state_d;
    logic [ARM_W-1:0]      arm_cnt_q;
    logic [ARM_W-1:0]      arm_cnt_d;

    // ------------------------------------------------------------------
    // Per-line conditioning
    // ------------------------------------------------------------------
    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_line
        gpio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i         (clock),
            .rst_ni        (reset),
            .pad_i         (gpio_input[i]),
            .stable_o      (gpio_stable[i]),
            .stable_next_o (stable_next[i])
        );
    end

    // ------------------------------------------------------------------
    // Arming FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        if (state_q == SETTLE) begin
            if (arm_cnt_q == ARM_LAST) begin
                state_d = ARMED;
            end else begin
                arm_cnt_d = arm_cnt_q + ARM_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= SETTLE;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Pending flags
    // ------------------------------------------------------------------
    // Edges are detected from the debouncer's next value so a flag sets on
    // the same edge the stable value changes. Enables and gpio_oe only gate
    // new events; they never touch flags already set. Set wins over clear.
    always_comb begin
        rise_evt    = stable_next & ~gpio_stable;
        fall_evt    = ~stable_next & gpio_stable;
        pending_set = '0;
        if (state_q == ARMED) begin
            pending_set = ~gpio_oe & ((rise_evt & rise_enable) | (fall_evt & fall_enable));
        end
        pending_d = (pending_q & ~irq_clear) | pending_set;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign irq_pending = pending_q;
    assign irq         = |pending_q;

endmodule : gpio_input_conditioner
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_input_conditioner
//  Purpose  : Self-checking bench for gpio_input_conditioner (3 lines,
//             4-cycle debounce window). Expected values are queued with the
//             cycle at which they must be observed when stimulus is driven.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_input_conditioner;

    localparam int W   = 3;
    localparam int D   = 4;
    localparam int LAT = D + 2;

    localparam int SEL_STABLE  = 0;
    localparam int SEL_PENDING = 1;
    localparam int SEL_IRQ     = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] gpio_input  = '0;
    logic [W-1:0] gpio_oe     = '0;
    logic [W-1:0] rise_enable = '0;
    logic [W-1:0] fall_enable = '0;
    logic [W-1:0] irq_clear   = '0;
    logic [W-1:0] gpio_stable;
    logic [W-1:0] irq_pending;
    logic         irq;

    gpio_input_conditioner #(
        .GPIO_WIDTH      (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .gpio_input  (gpio_input),
        .gpio_oe     (gpio_oe),
        .rise_enable (rise_enable),
        .fall_enable (fall_enable),
        .irq_clear   (irq_clear),
        .gpio_stable (gpio_stable),
        .irq_pending (irq_pending),
        .irq         (irq)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int           at;
        string        tag;
        int           sel;
        logic [W-1:0] exp;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input int at, input string tag, input int sel, input logic [W-1:0] exp);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [W-1:0] observe(input int sel);
        case (sel)
            SEL_STABLE:  return gpio_stable;
            SEL_PENDING: return irq_pending;
            default:     return {{(W-1){1'b0}}, irq};
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].at == cyc) begin
                check(sb[i].tag, 32'(observe(sb[i].sel)), 32'(sb[i].exp));
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int rel;

        // Reset holds everything low even with all pads high and enabled.
        gpio_input  = '1;
        rise_enable = '1;
        fall_enable = '1;
        tick(3);
        check("rst_stable",  32'(gpio_stable), 32'(0));
        check("rst_pending", 32'(irq_pending), 32'(0));
        check("rst_irq",     32'(irq),         32'(0));

        // Line 0 rises at release; it qualifies on the same edge the FSM
        // arms, so no flag may be raised.
        fall_enable = '0;
        rise_enable = 3'b001;
        gpio_input  = 3'b001;
        reset       = 1'b1;
        rel         = cyc;
        expect_at(rel + LAT - 1, "p1_stable_before", SEL_STABLE,  3'b000);
        expect_at(rel + LAT,     "p1_stable",        SEL_STABLE,  3'b001);
        expect_at(rel + LAT,     "p1_pend_settle",   SEL_PENDING, 3'b000);
        expect_at(rel + LAT + 1, "p1_irq",           SEL_IRQ,     3'b000);
        tick(10);

        // 3-cycle glitch on line 1 is rejected.
        c           = cyc;
        rise_enable = 3'b011;
        gpio_input  = 3'b011;
        expect_at(c + LAT,     "p2_glitch_stable", SEL_STABLE, 3'b001);
        expect_at(c + LAT + 2, "p2_glitch_stable2", SEL_STABLE, 3'b001);
        expect_at(c + LAT + 2, "p2_glitch_irq",    SEL_IRQ,    3'b000);
        tick(3);
        gpio_input = 3'b001;
        tick(8);

        // A pulse of exactly D cycles is accepted and flags a rise.
        c          = cyc;
        gpio_input = 3'b011;
        expect_at(c + LAT - 1, "p2b_stable_before", SEL_STABLE,  3'b001);
        expect_at(c + LAT,     "p2b_stable",        SEL_STABLE,  3'b011);
        expect_at(c + LAT,     "p2b_pending",       SEL_PENDING, 3'b010);
        expect_at(c + LAT,     "p2b_irq",           SEL_IRQ,     3'b001);
        expect_at(c + 9,       "p2b_pend_kept",     SEL_PENDING, 3'b010);
        expect_at(c + LAT + D, "p2b_stable_back",   SEL_STABLE,  3'b001);
        expect_at(c + 11,      "p2b_pend_preclr",   SEL_PENDING, 3'b010);
        expect_at(c + 12,      "p2b_pend_clr",      SEL_PENDING, 3'b000);
        expect_at(c + 12,      "p2b_irq_clr",       SEL_IRQ,     3'b000);
        tick(D);
        gpio_input = 3'b001;
        tick(3);
        // Changing enables / oe must leave the set flag alone.
        rise_enable = 3'b000;
        gpio_oe     = 3'b111;
        tick(4);
        gpio_oe     = 3'b000;
        rise_enable = 3'b011;
        irq_clear   = 3'b010;
        tick(1);
        irq_clear   = 3'b000;
        tick(3);

        // Line 2 high (no rise enable), then fall with simultaneous clear.
        c          = cyc;
        gpio_input = 3'b101;
        expect_at(c + LAT, "p3_stable_hi",  SEL_STABLE,  3'b101);
        expect_at(c + LAT, "p3_pend_norise", SEL_PENDING, 3'b000);
        tick(8);
        c           = cyc;
        fall_enable = 3'b100;
        gpio_input  = 3'b001;
        expect_at(c + LAT - 1, "p3_stable_before", SEL_STABLE,  3'b101);
        expect_at(c + LAT,     "p3_stable_lo",     SEL_STABLE,  3'b001);
        expect_at(c + LAT,     "p3_set_wins",      SEL_PENDING, 3'b100);
        expect_at(c + LAT,     "p3_irq_set",       SEL_IRQ,     3'b001);
        expect_at(c + LAT + 1, "p3_clear_alone",   SEL_PENDING, 3'b000);
        expect_at(c + LAT + 1, "p3_irq_clear",     SEL_IRQ,     3'b000);
        tick(LAT - 1);
        irq_clear = 3'b100;
        tick(2);
        irq_clear = 3'b000;
        tick(3);

        // Line 0 driven as output: stable follows, no events either way.
        c           = cyc;
        gpio_oe     = 3'b001;
        fall_enable = 3'b101;
        gpio_input  = 3'b000;
        expect_at(c + LAT, "p4_stable_lo", SEL_STABLE,  3'b000);
        expect_at(c + LAT, "p4_pend_fall", SEL_PENDING, 3'b000);
        tick(8);
        c          = cyc;
        gpio_input = 3'b001;
        expect_at(c + LAT - 1, "p4_stable_before", SEL_STABLE,  3'b000);
        expect_at(c + LAT,     "p4_stable_hi",     SEL_STABLE,  3'b001);
        expect_at(c + LAT,     "p4_pend_rise",     SEL_PENDING, 3'b000);
        expect_at(c + LAT + 1, "p4_irq",           SEL_IRQ,     3'b000);
        tick(10);

        // Reset at count 2 of line 1's debounce, held one cycle.
        gpio_oe    = 3'b000;
        gpio_input = 3'b011;
        tick(4);
        reset = 1'b0;
        #1;
        check("p5_rst_stable",  32'(gpio_stable), 32'(0));
        check("p5_rst_pending", 32'(irq_pending), 32'(0));
        check("p5_rst_irq",     32'(irq),         32'(0));
        tick(1);
        reset = 1'b1;
        rel   = cyc;
        expect_at(rel + LAT - 1, "p5_requal_before", SEL_STABLE,  3'b000);
        expect_at(rel + LAT,     "p5_requal",        SEL_STABLE,  3'b011);
        expect_at(rel + LAT,     "p5_pend_settle",   SEL_PENDING, 3'b000);
        expect_at(rel + LAT + 1, "p5_irq",           SEL_IRQ,     3'b000);
        tick(10);

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gpio_input_conditioner
`default_nettype wire
